// File: rtl/xpb_lut_pkg.sv
// Shared types and sizing helpers for the runtime-loadable XPB lookup store.
package xpb_lut_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_e;

  localparam int DEF_SEG_BITS   = 5;
  localparam int DEF_WORD_BITS  = 1024;
  localparam int DEF_NUM_TABLES = 8;
  localparam int DEF_LOAD_BITS  = 32;

  function automatic int beats_of(input int word_bits, input int load_bits);
    return word_bits / load_bits;
  endfunction

  function automatic int depth_of(input int seg_bits);
    return 1 << seg_bits;
  endfunction

  // Counter width that stays legal (>= 1 bit) for degenerate sizes of 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xpb_lut_bank.sv
// One XPB table: entries 1..2^SEG_BITS-1, single write port, registered read
// port that returns zero for segment 0 or when no read is requested.
module xpb_lut_bank
  import xpb_lut_pkg::*;
#(
  parameter int SEG_BITS  = DEF_SEG_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en_i,
  input  logic [SEG_BITS-1:0]  wr_idx_i,
  input  logic [WORD_BITS-1:0] wr_word_i,
  input  logic                 rd_en_i,
  input  logic [SEG_BITS-1:0]  rd_seg_i,
  output logic [WORD_BITS-1:0] rd_word_o
);

  localparam int DEPTH = depth_of(SEG_BITS);

  logic [WORD_BITS-1:0] mem_q [1:DEPTH-1];
  logic [WORD_BITS-1:0] rd_word_q;

  // NOTE: table storage is deliberately not reset; it stays unreachable until a
  // complete load sets tables_loaded, and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_word_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_word_q <= '0;
    end else if (rd_en_i && (rd_seg_i != '0)) begin
      rd_word_q <= mem_q[rd_seg_i];
    end else begin
      rd_word_q <= '0;
    end
  end

  assign rd_word_o = rd_word_q;

endmodule

// File: rtl/xpb_lut_ram.sv
// Multi-table XPB lookup store loaded over a narrow beat stream.
// Define XPB_LUT_OUT_REG_EN to add an output register stage (latency 2).
module xpb_lut_ram
  import xpb_lut_pkg::*;
#(
  parameter int SEG_BITS   = DEF_SEG_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int NUM_TABLES = DEF_NUM_TABLES,
  parameter int LOAD_BITS  = DEF_LOAD_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_start,
  input  logic [LOAD_BITS-1:0]            ld_data,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  output logic                            tables_loaded,
  input  logic                            rd_en,
  input  logic [NUM_TABLES*SEG_BITS-1:0]  rd_seg,
  output logic [NUM_TABLES*WORD_BITS-1:0] rd_data,
  output logic                            rd_valid
);

  localparam int BEATS  = beats_of(WORD_BITS, LOAD_BITS);
  localparam int DEPTH  = depth_of(SEG_BITS);
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int TBL_W  = cnt_w(NUM_TABLES);

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [SEG_BITS-1:0]  idx_q, idx_d;
  logic [TBL_W-1:0]     tbl_q, tbl_d;
  logic                 loaded_q, loaded_d;
  logic                 rd_valid1_q;
  logic [WORD_BITS-1:0] asm_q;
  logic [WORD_BITS-1:0] wr_word;
  logic                 accept;
  logic                 wr_en;
  logic                 rd_req;
  logic [NUM_TABLES*WORD_BITS-1:0] rd_word1;

  assign ld_ready      = (state_q == LOAD);
  assign tables_loaded = loaded_q;
  // A restart in the same cycle drops the beat.
  assign accept        = ld_valid && ld_ready && !load_start;
  assign rd_req        = rd_en && loaded_q;
  // Beats shift in from the top, so the first beat ends up least significant.
  assign wr_word       = {ld_data, asm_q[WORD_BITS-1:LOAD_BITS]};

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    idx_d    = idx_q;
    tbl_d    = tbl_q;
    loaded_d = loaded_q;
    wr_en    = 1'b0;
    if (load_start) begin
      state_d  = LOAD;
      beat_d   = '0;
      idx_d    = SEG_BITS'(1);
      tbl_d    = '0;
      loaded_d = 1'b0;
    end else if (state_q == LOAD && accept) begin
      if (beat_q == BEAT_W'(BEATS - 1)) begin
        wr_en  = 1'b1;
        beat_d = '0;
        if (idx_q == SEG_BITS'(DEPTH - 1)) begin
          idx_d = SEG_BITS'(1);
          if (tbl_q == TBL_W'(NUM_TABLES - 1)) begin
            tbl_d    = '0;
            state_d  = READY;
            loaded_d = 1'b1;
          end else begin
            tbl_d = tbl_q + TBL_W'(1);
          end
        end else begin
          idx_d = idx_q + SEG_BITS'(1);
        end
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      idx_q       <= '0;
      tbl_q       <= '0;
      loaded_q    <= 1'b0;
      rd_valid1_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      tbl_q       <= tbl_d;
      loaded_q    <= loaded_d;
      rd_valid1_q <= rd_req;
    end
  end

  // A restarted entry always collects a full set of fresh beats before being
  // written, so the assembly register needs no reset or clear.
  always_ff @(posedge clk) begin
    if (accept) asm_q <= wr_word;
  end

  for (genvar t = 0; t < NUM_TABLES; t++) begin : g_bank
    xpb_lut_bank #(
      .SEG_BITS  (SEG_BITS),
      .WORD_BITS (WORD_BITS)
    ) u_bank (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en && (tbl_q == TBL_W'(t))),
      .wr_idx_i  (idx_q),
      .wr_word_i (wr_word),
      .rd_en_i   (rd_req),
      .rd_seg_i  (rd_seg[t*SEG_BITS +: SEG_BITS]),
      .rd_word_o (rd_word1[t*WORD_BITS +: WORD_BITS])
    );
  end

`ifdef XPB_LUT_OUT_REG_EN
  logic [NUM_TABLES*WORD_BITS-1:0] rd_data_q;
  logic                            rd_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_word1;
      rd_valid_q <= rd_valid1_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  assign rd_data  = rd_word1;
  assign rd_valid = rd_valid1_q;
`endif

endmodule

// File: tb/tb_xpb_lut_ram.sv
// Self-checking bench for xpb_lut_ram: vector table, array reference model,
// randomized lookups and the load/restart corner sequences.
module tb_xpb_lut_ram;

  localparam int SB    = 5;
  localparam int WB    = 1024;
  localparam int NT    = 8;
  localparam int LB    = 32;
  localparam int DEPTH = 32;
  localparam int BEATS = WB / LB;
  localparam int TOTAL = NT * (DEPTH - 1) * BEATS;
`ifdef XPB_LUT_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset, load_start, ld_valid, rd_en;
  logic              ld_ready, tables_loaded, rd_valid;
  logic [LB-1:0]     ld_data;
  logic [NT*SB-1:0]  rd_seg;
  logic [NT*WB-1:0]  rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;

  logic [WB-1:0] model [NT][DEPTH];
  logic [WB-1:0] pend  [NT][DEPTH];

  typedef struct {
    string       name;
    logic        en;
    logic [SB-1:0] seg [NT];
    logic        ev;
    logic [31:0] rep [NT];
  } vec_t;
  vec_t vecs [5];

  xpb_lut_ram #(
    .SEG_BITS(SB), .WORD_BITS(WB), .NUM_TABLES(NT), .LOAD_BITS(LB)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .ld_data(ld_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .tables_loaded(tables_loaded),
    .rd_en(rd_en), .rd_seg(rd_seg), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ld_valid && ld_ready && !load_start && !reset) hs_cnt <= hs_cnt + 1;

  task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lo=%h hi=%h, want lo=%h hi=%h",
               name, act[31:0], act[WB-1 -: 32], exp[31:0], exp[WB-1 -: 32]);
    end
  endtask

  task automatic fill_pattern_a();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < DEPTH; i++)
        pend[t][i] = (i == 0) ? '0 : {32{32'(t * 32 + i)}};
  endtask

  task automatic fill_random();
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < DEPTH; i++)
        for (int b = 0; b < BEATS; b++)
          pend[t][i][b*LB +: LB] = (i == 0) ? '0 : $urandom;
  endtask

  // Streams pend[][] in load order; abort_after >= 0 restarts on that beat.
  task automatic do_load(input int abort_after, input bit toggle);
    int nb;
    nb = 0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("ld_ready_in_load", ld_ready, 1);
    check("loaded_clear_in_load", tables_loaded, 0);
    for (int t = 0; t < NT; t++)
      for (int i = 1; i < DEPTH; i++)
        for (int b = 0; b < BEATS; b++) begin
          if (toggle) begin
            ld_valid = 1'b0;
            @(posedge clk); #1;
          end
          ld_valid = 1'b1;
          ld_data  = pend[t][i][b*LB +: LB];
          if (nb == abort_after) begin
            load_start = 1'b1;
            @(posedge clk); #1;
            load_start = 1'b0;
            ld_valid   = 1'b0;
            return;
          end
          @(posedge clk); #1;
          nb++;
        end
    ld_valid = 1'b0;
  endtask

  task automatic wait_lat();
    repeat (LAT - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic verify_all(input string tag);
    for (int s = 0; s < DEPTH; s++) begin
      rd_en = 1'b1;
      for (int t = 0; t < NT; t++) rd_seg[t*SB +: SB] = SB'(s);
      @(posedge clk); #1;
      rd_en = 1'b0;
      wait_lat();
      check($sformatf("%s_valid_s%0d", tag, s), rd_valid, 1);
      for (int t = 0; t < NT; t++)
        check($sformatf("%s_t%0d_s%0d", tag, t, s), rd_data[t*WB +: WB], model[t][s]);
    end
  endtask

  task automatic run_table();
    for (int v = 0; v < 5; v++) begin
      rd_en = vecs[v].en;
      for (int t = 0; t < NT; t++) rd_seg[t*SB +: SB] = vecs[v].seg[t];
      @(posedge clk); #1;
      rd_en = 1'b0;
      wait_lat();
      check({vecs[v].name, "_valid"}, rd_valid, vecs[v].ev);
      for (int t = 0; t < NT; t++)
        check($sformatf("%s_ch%0d", vecs[v].name, t), rd_data[t*WB +: WB], {32{vecs[v].rep[t]}});
    end
  endtask

  task automatic run_stream(input string tag, input int n, input bit rnd);
    bit               q_en  [$];
    logic [NT*SB-1:0] q_seg [$];
    bit               e;
    logic [NT*SB-1:0] s;
    for (int c = 0; c < n + LAT - 1; c++) begin
      if (c < n) begin
        rd_en = rnd ? ($urandom_range(3) != 0) : 1'b1;
        for (int t = 0; t < NT; t++)
          rd_seg[t*SB +: SB] = rnd ? SB'($urandom) : SB'(c + t);
        q_en.push_back(rd_en);
        q_seg.push_back(rd_seg);
      end else begin
        rd_en = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= LAT - 1) begin
        e = q_en.pop_front();
        s = q_seg.pop_front();
        check($sformatf("%s_valid_%0d", tag, c), rd_valid, e);
        for (int t = 0; t < NT; t++)
          check($sformatf("%s_%0d_ch%0d", tag, c, t), rd_data[t*WB +: WB],
                e ? model[t][s[t*SB +: SB]] : '0);
      end
    end
    rd_en = 1'b0;
  endtask

  initial begin
    int hs0;
    bit v_obs [3];
    logic [WB-1:0] d_obs [3];
    bit tl_obs [3];

    vecs[0].name = "seg0_all"; vecs[0].en = 1; vecs[0].ev = 1;
    vecs[0].seg = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    vecs[0].rep = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00};
    vecs[1].name = "seg1f_all"; vecs[1].en = 1; vecs[1].ev = 1;
    vecs[1].seg = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
    vecs[1].rep = '{32'h1F, 32'h3F, 32'h5F, 32'h7F, 32'h9F, 32'hBF, 32'hDF, 32'hFF};
    vecs[2].name = "no_rd_en"; vecs[2].en = 0; vecs[2].ev = 0;
    vecs[2].seg = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
    vecs[2].rep = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h00};
    vecs[3].name = "seg_t_plus1"; vecs[3].en = 1; vecs[3].ev = 1;
    vecs[3].seg = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08};
    vecs[3].rep = '{32'h01, 32'h22, 32'h43, 32'h64, 32'h85, 32'hA6, 32'hC7, 32'hE8};
    vecs[4].name = "seg_mixed"; vecs[4].en = 1; vecs[4].ev = 1;
    vecs[4].seg = '{5'h00, 5'h05, 5'h1F, 5'h00, 5'h03, 5'h10, 5'h00, 5'h1E};
    vecs[4].rep = '{32'h00, 32'h25, 32'h5F, 32'h00, 32'h83, 32'hB0, 32'h00, 32'hFE};

    for (int t = 0; t < NT; t++)
      for (int i = 0; i < DEPTH; i++) model[t][i] = '0;

    reset = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    rd_en = 1'b0; rd_seg = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Lookups before any load must stay invalid and zero.
    rd_en = 1'b1;
    rd_seg[SB-1:0] = 5'h03;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_valid_%0d", c), rd_valid, 0);
      check($sformatf("rst_data_%0d", c), rd_data[WB-1:0], '0);
      check($sformatf("rst_loaded_%0d", c), tables_loaded, 0);
      check($sformatf("rst_ld_ready_%0d", c), ld_ready, 0);
    end
    rd_en = 1'b0;

    // Full load of the reference pattern.
    fill_pattern_a();
    hs0 = hs_cnt;
    do_load(-1, 1'b0);
    model = pend;
    check("a_handshakes", 32'(hs_cnt - hs0), 32'(TOTAL));
    check("a_loaded", tables_loaded, 1);
    check("a_ld_ready_low", ld_ready, 0);
    run_table();
    verify_all("a");
    run_stream("b2b", 64, 1'b0);

    // Abort after 100 beats (restart coincides with a beat), then new pattern.
    fill_random();
    do_load(100, 1'b0);
    check("abort_loaded_low", tables_loaded, 0);
    check("abort_ld_ready", ld_ready, 1);
    fill_random();
    do_load(-1, 1'b0);
    model = pend;
    check("r_loaded", tables_loaded, 1);
    verify_all("r");
    run_stream("rnd", 200, 1'b1);

    // Reload the reference pattern with a gappy ld_valid.
    fill_pattern_a();
    hs0 = hs_cnt;
    do_load(-1, 1'b1);
    model = pend;
    check("tog_handshakes", 32'(hs_cnt - hs0), 32'(TOTAL));
    check("tog_loaded", tables_loaded, 1);
    run_table();
    verify_all("tog");

    // load_start together with a lookup in READY.
    rd_en = 1'b1;
    for (int t = 0; t < NT; t++) rd_seg[t*SB +: SB] = 5'h1F;
    load_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      load_start = 1'b0;
      v_obs[k]  = rd_valid;
      d_obs[k]  = rd_data[2*WB +: WB];
      tl_obs[k] = tables_loaded;
    end
    rd_en = 1'b0;
    check("coinc_valid", v_obs[LAT-1], 1);
    check("coinc_data", d_obs[LAT-1], {32{32'h5F}});
    check("coinc_next_valid", v_obs[LAT], 0);
    check("coinc_next_data", d_obs[LAT], '0);
    check("coinc_loaded_clear", tl_obs[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xpb_lut_ram.md
# xpb_lut_ram

Runtime-loadable, multi-table XPB lookup store for the modular squaring datapath. It replaces fixed per-segment constant tables with storage loaded over a narrow stream. A new modulus or reduction window therefore needs no re-synthesis. It serves NUM_TABLES parallel segment lookups per cycle and sits between the squarer's partial-product segmenter and the reduction adder tree.

## Interface
Parameters:
- SEG_BITS, 5, segment (lookup address) width; table depth 2^SEG_BITS
- WORD_BITS, 1024, width of each stored XPB value
- NUM_TABLES, 8, independent tables / parallel lookup channels
- LOAD_BITS, 32, load stream width; WORD_BITS must be a multiple of LOAD_BITS

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- load_start  in  1  pulse: invalidate contents and begin (re)load
- ld_data  in  LOAD_BITS  load beat
- ld_valid  in  1  beat valid
- ld_ready  out  1  beat accepted when ld_valid & ld_ready
- tables_loaded  out  1  all tables written since last load_start
- rd_en  in  1  lookup request, all channels together
- rd_seg  in  NUM_TABLES*SEG_BITS  channel t address at [t*SEG_BITS +: SEG_BITS]
- rd_data  out  NUM_TABLES*WORD_BITS  channel t result at [t*WORD_BITS +: WORD_BITS]
- rd_valid  out  1  rd_data valid

## Operation
- FSM states: IDLE, LOAD, READY. Reset forces IDLE.
- IDLE -> LOAD on load_start. READY -> LOAD on load_start. LOAD + load_start restarts the load: counters cleared, partial entry discarded.
- ld_ready = 1 only in LOAD.
- Load order: table 0..NUM_TABLES-1; within a table, index 1..2^SEG_BITS-1; within an entry, BEATS = WORD_BITS/LOAD_BITS beats, least-significant beat first.
- Total beats per load = NUM_TABLES*(2^SEG_BITS-1)*BEATS. Default is 8*31*32 = 7936.
- Assembly register collects beats. On the accepted last beat of an entry, the entry is written to (table, index). Beat counter then wraps to 0 and the index advances. Index wraps 31 -> 1 with the table incremented.
- Final beat of the final table: write, go to READY, tables_loaded <= 1.
- tables_loaded clears on the cycle after load_start or reset.
- Index 0 is never stored. Any lookup of segment 0 returns all-zero.
- Lookup: rd_valid asserts for a request only if rd_en & tables_loaded in the request cycle. Otherwise rd_valid = 0 and rd_data = 0.
- Lookups and loading are mutually exclusive by construction, since tables_loaded = 0 in LOAD.
- ld_valid with ld_ready = 0 is ignored and nothing is written.

## Timing
- Lookup latency 1 cycle by default: rd_en/rd_seg at cycle n -> rd_data/rd_valid at n+1. Fully pipelined, one request per cycle.
- Output rd_data holds zero when rd_valid = 0.
- Reset values: ld_ready 0, tables_loaded 0, rd_valid 0, rd_data 0, FSM IDLE, all counters 0.
- Reset does not clear table storage. Stale contents are unreachable because tables_loaded = 0.
- Reset mid-load: load aborted; a fresh load_start is required.
- load_start coincident with an accepted beat: restart wins and the beat is dropped.
- load_start coincident with rd_en while in READY: this lookup still returns valid data at n+1. Lookups from n+1 onward are suppressed.

## Configuration
- XPB_LUT_OUT_REG_EN defined:
  - adds a second register stage on rd_data/rd_valid, for timing closure of the wide fan-out
  - lookup latency 2 cycles; throughput unchanged
  - the extra stage resets to 0
- XPB_LUT_OUT_REG_EN undefined: latency 1 as above.

## Structure
- Package xpb_lut_pkg holds:
  - FSM state enum (IDLE, LOAD, READY)
  - localparam helpers: BEATS, depth = 2^SEG_BITS, beat/index/table counter widths via $clog2
- Sub-module xpb_lut_bank, instantiated NUM_TABLES times:
  - one table of 2^SEG_BITS-1 entries x WORD_BITS
  - one write port: en, index, word
  - one registered read port with segment-0 zero forcing
- The top module holds the FSM, counters, assembly register and output pipeline.

## Test plan
- Reset, then rd_en = 1 with rd_seg channel 0 = 5'h03:
  - rd_valid = 0 and rd_data = 0 on every cycle
  - tables_loaded = 0, ld_ready = 0
- Load pattern where word (t,i) = {32{t*32+i}}:
  - after 7936 accepted beats, tables_loaded = 1
  - rd_seg channel 2 = 5'h1F gives rd_data channel 2 = {32{32'h5F}} one cycle later (two with XPB_LUT_OUT_REG_EN)
  - segment 0 on any channel gives 0
- Load with ld_valid toggling every other cycle:
  - identical final contents
  - no beats lost or duplicated; exactly 7936 handshakes
- load_start asserted after 100 beats, then a full reload with a new pattern:
  - all lookups return new-pattern values
  - no word mixes beats from the aborted load
- Back-to-back rd_en for 64 cycles with incrementing segments:
  - rd_valid continuous for 64 cycles
  - each result matches its segment with the configured latency
- load_start in the same cycle as rd_en in READY:
  - that request returns valid data
  - the next cycle's request gives rd_valid = 0
  - tables_loaded = 0 from the following cycle
